load_buf_tracker: RTL and testbench
===================================

Name: load_buf_tracker

Overview:
- Tracks outstanding data-cache loads between load-unit issue and the write-through dcache response port.
- Holds NR_ENTRIES in-flight load descriptors: scoreboard transaction id, byte offset, size, sign flag.
- Allocates a cache request tag per load and matches returned data by tag.
- Aligns and sign/zero-extends the returned word, then drives the writeback result registered.
- Supports per-tag kill and global flush, for replayed loads and pipeline flush.

Parameters:
- NR_ENTRIES, 2, number of in-flight loads (≥2).
- TAG_W, 1, cache request tag width = max(1, clog2(NR_ENTRIES)).
- TRANS_ID_W, 2, scoreboard transaction id width = clog2(NrScoreboardEntries=4).
- XLEN, 32, data width (32 only; offset is 2 bits).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  kill all occupied entries.
- req_valid_i  in  1  load issue request.
- req_ready_o  out  1  a free entry exists.
- req_trans_id_i  in  TRANS_ID_W  scoreboard id.
- req_offset_i  in  2  byte offset in word.
- req_size_i  in  2  0=byte, 1=half, 2=word.
- req_signed_i  in  1  sign-extend result.
- req_tag_o  out  TAG_W  tag assigned to the accepted request (combinational, valid when req_valid_i && req_ready_o).
- kill_valid_i  in  1  kill one entry.
- kill_tag_i  in  TAG_W  entry to kill.
- rsp_valid_i  in  1  cache data return.
- rsp_tag_i  in  TAG_W  tag of return.
- rsp_data_i  in  XLEN  raw word.
- result_valid_o  out  1  writeback valid (one-cycle pulse).
- result_trans_id_o  out  TRANS_ID_W  writeback id.
- result_data_o  out  XLEN  aligned/extended data.
- empty_o  out  1  no occupied entries.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, rst_ni.
- Reset state: all entries free and not killed; result_valid_o=0; result_trans_id_o=0; result_data_o=0; empty_o=1.
- Per-entry state: FREE → BUSY (on accept) → FREE (on response). BUSY with killed=1 is a sub-state.
- req_ready_o: 1 iff any entry is FREE in registered state. An entry freed this cycle is not allocatable until the next cycle.
- Allocation: a request is accepted when req_valid_i && req_ready_o. It takes the lowest-index FREE entry; req_tag_o = that index. The descriptor is captured on the clock edge.
- Response, entry BUSY and not killed: entry is freed. Next cycle result_valid_o=1, result_trans_id_o=stored id.
- Response, entry BUSY and killed: entry is freed; no result is produced (result_valid_o=0).
- Response for a FREE tag: protocol error. Assertion fires; state is unchanged.
- Extraction: shift rsp_data_i right by offset*8.
  - Byte: bits [7:0], extended with bit7 if signed.
  - Half: bits [15:0], extended with bit15 if signed.
  - Word: pass-through.
  - Half with offset 1 or 3, word with offset≠0, and size 3 are illegal (assertion). Output for these is don't-care.
- Kill: kill_valid_i on a BUSY entry sets killed. Kill on a FREE entry is ignored.
- Kill and response to the same tag in the same cycle: the response is suppressed and the entry is freed.
- Flush: sets killed on every BUSY entry. Entries stay occupied until their response returns, because the cache always answers.
- Flush and accept in the same cycle: the new entry is NOT killed.
- Flush and response in the same cycle: that response is suppressed.
- Kill, flush and response on the same entry in one cycle: the entry is freed and no result is produced.
- Simultaneous accept and response: both occur. Accept uses only an entry that was FREE in registered state.
- No backpressure on result: result_valid_o is a single-cycle pulse, and a back-to-back response next cycle overwrites the result register.
- empty_o: registered. It is 1 iff all entries are FREE after the edge.
- Reset mid-operation: all state clears immediately. Responses in flight after reset hit FREE tags; the bench must not drive them.

Test Plan:
- Single signed byte: accept id=2, offset=1, size=0, signed=1, tag=0. Then rsp tag 0, data 32'h0000_8000. → Next cycle result_valid_o=1, id=2, data=32'hFFFF_FF80.
- Fill and out-of-order return:
  - Accept two loads → tags 0 and 1; req_ready_o=0.
  - rsp tag1 (half unsigned, offset2, data 32'hBEEF_1234) → result 32'h0000_BEEF.
  - Same cycle, a new request is refused; the next cycle it gets tag 1.
- Kill: accept tag0, then kill_tag_i=0. rsp tag0 → no result_valid_o, entry freed, empty_o=1 the following cycle.
- Flush with two busy entries, and accept in the same cycle while one entry is FREE:
  - Old entries' responses are suppressed.
  - The new entry's response produces a result.
- Same-cycle kill and response on tag1 → no result; tag1 is allocatable the next cycle.
- Assert rst_ni=0 asynchronously while two loads are busy → req_ready_o=1, empty_o=1 and result_valid_o=0 before the next clock edge.

Source files
------------

// File: rtl/load_buf_tracker.sv
// In-flight load tracker between load issue and the dcache response port.
// Hands out request tags, matches returns by tag, and drives the aligned writeback result.
module load_buf_tracker #(
    parameter int unsigned NR_ENTRIES = 2,
    parameter int unsigned TAG_W      = 1,
    parameter int unsigned TRANS_ID_W = 2,
    parameter int unsigned XLEN       = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [TRANS_ID_W-1:0] req_trans_id_i,
    input  logic [1:0]            req_offset_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_signed_i,
    output logic [TAG_W-1:0]      req_tag_o,
    input  logic                  kill_valid_i,
    input  logic [TAG_W-1:0]      kill_tag_i,
    input  logic                  rsp_valid_i,
    input  logic [TAG_W-1:0]      rsp_tag_i,
    input  logic [XLEN-1:0]       rsp_data_i,
    output logic                  result_valid_o,
    output logic [TRANS_ID_W-1:0] result_trans_id_o,
    output logic [XLEN-1:0]       result_data_o,
    output logic                  empty_o
);

    // state | meaning
    // FREE  | entry holds no load, allocatable
    // BUSY  | load issued, waiting for its cache response (killed_q marks a dead load)
    typedef enum logic {FREE = 1'b0, BUSY = 1'b1} entry_state_e;

    entry_state_e          state_q  [NR_ENTRIES];
    entry_state_e          state_d  [NR_ENTRIES];
    logic                  killed_q [NR_ENTRIES];
    logic                  killed_d [NR_ENTRIES];
    logic [TRANS_ID_W-1:0] id_q     [NR_ENTRIES];
    logic [1:0]            offset_q [NR_ENTRIES];
    logic [1:0]            size_q   [NR_ENTRIES];
    logic                  signed_q [NR_ENTRIES];

    logic                  result_valid_q;
    logic [TRANS_ID_W-1:0] result_trans_id_q;
    logic [XLEN-1:0]       result_data_q;
    logic                  empty_q;

    logic                  any_free;
    logic [TAG_W-1:0]      alloc_idx;
    logic                  accept;
    logic                  rsp_hit;
    logic                  rsp_dead;
    logic                  result_valid_d;
    logic [XLEN-1:0]       shifted;
    logic [XLEN-1:0]       extracted;
    logic                  empty_d;

    // Lowest-index free entry, based on registered state only.
    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                any_free  = 1'b1;
                alloc_idx = TAG_W'(i);
            end
        end
    end

    assign req_ready_o = any_free;
    assign req_tag_o   = alloc_idx;
    assign accept      = req_valid_i && any_free;

    assign rsp_hit  = rsp_valid_i && (state_q[rsp_tag_i] == BUSY);
    assign rsp_dead = killed_q[rsp_tag_i] || flush_i ||
                      (kill_valid_i && (kill_tag_i == rsp_tag_i));

    always_comb begin
        shifted   = rsp_data_i >> {offset_q[rsp_tag_i], 3'b000};
        extracted = shifted;
        case (size_q[rsp_tag_i])
            2'd0:    extracted = {{(XLEN-8){signed_q[rsp_tag_i] & shifted[7]}}, shifted[7:0]};
            2'd1:    extracted = {{(XLEN-16){signed_q[rsp_tag_i] & shifted[15]}}, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

    always_comb begin
        result_valid_d = rsp_hit && !rsp_dead;
        empty_d        = 1'b1;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            state_d[i]  = state_q[i];
            killed_d[i] = killed_q[i];
            if (state_q[i] == BUSY) begin
                if (flush_i || (kill_valid_i && (kill_tag_i == TAG_W'(i))))
                    killed_d[i] = 1'b1;
                if (rsp_hit && (rsp_tag_i == TAG_W'(i))) begin
                    state_d[i]  = FREE;
                    killed_d[i] = 1'b0;
                end
            end else if (accept && (alloc_idx == TAG_W'(i))) begin
                // A load accepted alongside a flush is younger than the flush.
                state_d[i]  = BUSY;
                killed_d[i] = 1'b0;
            end
            if (state_d[i] == BUSY)
                empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                state_q[i]  <= FREE;
                killed_q[i] <= 1'b0;
                id_q[i]     <= '0;
                offset_q[i] <= '0;
                size_q[i]   <= '0;
                signed_q[i] <= 1'b0;
            end
            result_valid_q    <= 1'b0;
            result_trans_id_q <= '0;
            result_data_q     <= '0;
            empty_q           <= 1'b1;
        end else begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                state_q[i]  <= state_d[i];
                killed_q[i] <= killed_d[i];
            end
            if (accept) begin
                id_q[alloc_idx]     <= req_trans_id_i;
                offset_q[alloc_idx] <= req_offset_i;
                size_q[alloc_idx]   <= req_size_i;
                signed_q[alloc_idx] <= req_signed_i;
            end
            result_valid_q <= result_valid_d;
            if (result_valid_d) begin
                result_trans_id_q <= id_q[rsp_tag_i];
                result_data_q     <= extracted;
            end
            empty_q <= empty_d;
        end
    end

    assign result_valid_o    = result_valid_q;
    assign result_trans_id_o = result_trans_id_q;
    assign result_data_o     = result_data_q;
    assign empty_o           = empty_q;

    rsp_to_busy_tag: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_valid_i |-> (state_q[rsp_tag_i] == BUSY));

    legal_size_offset: assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> !((req_size_i == 2'd3) ||
                     (req_size_i == 2'd1 && req_offset_i[0]) ||
                     (req_size_i == 2'd2 && req_offset_i != 2'd0)));

endmodule

// File: tb/tb_load_buf_tracker.sv
// Directed bench for load_buf_tracker: allocation, out-of-order return, kill, flush, reset.
module tb_load_buf_tracker;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_trans_id_i;
    logic [1:0]  req_offset_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [0:0]  req_tag_o;
    logic        kill_valid_i;
    logic [0:0]  kill_tag_i;
    logic        rsp_valid_i;
    logic [0:0]  rsp_tag_i;
    logic [31:0] rsp_data_i;
    logic        result_valid_o;
    logic [1:0]  result_trans_id_o;
    logic [31:0] result_data_o;
    logic        empty_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    load_buf_tracker dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_trans_id_i(req_trans_id_i), .req_offset_i(req_offset_i),
        .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_tag_o(req_tag_o),
        .kill_valid_i(kill_valid_i), .kill_tag_i(kill_tag_i),
        .rsp_valid_i(rsp_valid_i), .rsp_tag_i(rsp_tag_i), .rsp_data_i(rsp_data_i),
        .result_valid_o(result_valid_o), .result_trans_id_o(result_trans_id_o),
        .result_data_o(result_data_o), .empty_o(empty_o)
    );

    task automatic idle();
        flush_i = 0; req_valid_i = 0; req_trans_id_i = 0; req_offset_i = 0;
        req_size_i = 0; req_signed_i = 0; kill_valid_i = 0; kill_tag_i = 0;
        rsp_valid_i = 0; rsp_tag_i = 0; rsp_data_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] id, input logic [1:0] off,
                             input logic [1:0] size, input logic sgn);
        req_valid_i = 1; req_trans_id_i = id; req_offset_i = off;
        req_size_i = size; req_signed_i = sgn;
    endtask

    task automatic drive_rsp(input logic [0:0] tag, input logic [31:0] data);
        rsp_valid_i = 1; rsp_tag_i = tag; rsp_data_i = data;
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 0;
        #12;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty_o); end
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", result_valid_o); end
        checks++; if (result_trans_id_o !== 2'd0) begin errors++; $display("FAIL reset_rid got %0d want 0", result_trans_id_o); end
        checks++; if (result_data_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", result_data_o); end
        @(negedge clk_i);
        rst_ni = 1;
        tick();
    endtask

    task automatic test_single_byte();
        drive_req(2'd2, 2'd1, 2'd0, 1'b1);
        #1;
        checks++; if (req_tag_o !== 1'b0) begin errors++; $display("FAIL sb_tag got %0d want 0", req_tag_o); end
        tick(); idle();
        checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL sb_empty_busy got %b want 0", empty_o); end
        drive_rsp(1'b0, 32'h0000_8000);
        tick(); idle();
        checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL sb_rvalid got %b want 1", result_valid_o); end
        checks++; if (result_trans_id_o !== 2'd2) begin errors++; $display("FAIL sb_rid got %0d want 2", result_trans_id_o); end
        checks++; if (result_data_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL sb_rdata got %h want ffffff80", result_data_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL sb_empty got %b want 1", empty_o); end
        tick();
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL sb_pulse got %b want 0", result_valid_o); end
    endtask

    task automatic test_fill_ooo();
        drive_req(2'd1, 2'd0, 2'd2, 1'b0);
        tick();
        drive_req(2'd3, 2'd2, 2'd1, 1'b0);
        #1;
        checks++; if (req_tag_o !== 1'b1) begin errors++; $display("FAIL fill_tag1 got %0d want 1", req_tag_o); end
        tick(); idle();
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL fill_full got %b want 0", req_ready_o); end
        drive_rsp(1'b1, 32'hBEEF_1234);
        drive_req(2'd0, 2'd3, 2'd0, 1'b0);
        #1;
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL fill_refuse got %b want 0", req_ready_o); end
        tick();
        rsp_valid_i = 0;
        checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL fill_rvalid got %b want 1", result_valid_o); end
        checks++; if (result_trans_id_o !== 2'd3) begin errors++; $display("FAIL fill_rid got %0d want 3", result_trans_id_o); end
        checks++; if (result_data_o !== 32'h0000_BEEF) begin errors++; $display("FAIL fill_rdata got %h want 0000beef", result_data_o); end
        checks++; if (req_ready_o !== 1'b1 || req_tag_o !== 1'b1) begin errors++; $display("FAIL fill_realloc got ready %b tag %0d want 1 1", req_ready_o, req_tag_o); end
        tick(); idle();
        drive_rsp(1'b0, 32'h1234_5678);
        tick(); idle();
        checks++; if (result_trans_id_o !== 2'd1 || result_data_o !== 32'h1234_5678) begin errors++; $display("FAIL fill_word got id %0d data %h want 1 12345678", result_trans_id_o, result_data_o); end
        drive_rsp(1'b1, 32'hA500_0000);
        tick(); idle();
        checks++; if (result_valid_o !== 1'b1 || result_trans_id_o !== 2'd0 || result_data_o !== 32'h0000_00A5) begin errors++; $display("FAIL fill_byte3 got v %b id %0d data %h want 1 0 000000a5", result_valid_o, result_trans_id_o, result_data_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL fill_empty got %b want 1", empty_o); end
    endtask

    task automatic test_kill();
        drive_req(2'd1, 2'd0, 2'd0, 1'b0);
        tick(); idle();
        kill_valid_i = 1; kill_tag_i = 1'b0;
        tick(); idle();
        drive_rsp(1'b0, 32'h0000_0077);
        tick(); idle();
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL kill_rvalid got %b want 0", result_valid_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL kill_empty got %b want 1", empty_o); end
    endtask

    task automatic test_flush();
        drive_req(2'd0, 2'd0, 2'd2, 1'b0);
        tick();
        drive_req(2'd1, 2'd0, 2'd2, 1'b0);
        tick(); idle();
        drive_rsp(1'b1, 32'h0000_0001);
        tick(); idle();
        flush_i = 1;
        drive_req(2'd2, 2'd0, 2'd1, 1'b1);
        #1;
        checks++; if (req_tag_o !== 1'b1) begin errors++; $display("FAIL flush_tag got %0d want 1", req_tag_o); end
        tick(); idle();
        drive_rsp(1'b0, 32'hDEAD_BEEF);
        tick(); idle();
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL flush_old got %b want 0", result_valid_o); end
        drive_rsp(1'b1, 32'h0000_8001);
        tick(); idle();
        checks++; if (result_valid_o !== 1'b1 || result_trans_id_o !== 2'd2 || result_data_o !== 32'hFFFF_8001) begin errors++; $display("FAIL flush_new got v %b id %0d data %h want 1 2 ffff8001", result_valid_o, result_trans_id_o, result_data_o); end
        drive_req(2'd3, 2'd0, 2'd2, 1'b0);
        tick(); idle();
        flush_i = 1;
        drive_rsp(1'b0, 32'h5555_5555);
        tick(); idle();
        checks++; if (result_valid_o !== 1'b0 || empty_o !== 1'b1) begin errors++; $display("FAIL flush_rsp got v %b empty %b want 0 1", result_valid_o, empty_o); end
    endtask

    task automatic test_back_to_back();
        drive_req(2'd0, 2'd0, 2'd2, 1'b0);
        tick();
        drive_req(2'd1, 2'd0, 2'd2, 1'b0);
        tick(); idle();
        kill_valid_i = 1; kill_tag_i = 1'b1;
        drive_rsp(1'b1, 32'h0000_0099);
        tick(); idle();
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL krsp_rvalid got %b want 0", result_valid_o); end
        drive_req(2'd2, 2'd0, 2'd2, 1'b0);
        #1;
        checks++; if (req_ready_o !== 1'b1 || req_tag_o !== 1'b1) begin errors++; $display("FAIL krsp_realloc got ready %b tag %0d want 1 1", req_ready_o, req_tag_o); end
        tick(); idle();
        drive_rsp(1'b0, 32'h0000_0011);
        tick(); idle();
        checks++; if (result_valid_o !== 1'b1 || result_trans_id_o !== 2'd0 || result_data_o !== 32'h11) begin errors++; $display("FAIL b2b_first got v %b id %0d data %h want 1 0 00000011", result_valid_o, result_trans_id_o, result_data_o); end
        drive_rsp(1'b1, 32'h0000_0022);
        tick(); idle();
        checks++; if (result_valid_o !== 1'b1 || result_trans_id_o !== 2'd2 || result_data_o !== 32'h22) begin errors++; $display("FAIL b2b_second got v %b id %0d data %h want 1 2 00000022", result_valid_o, result_trans_id_o, result_data_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b want 1", empty_o); end
    endtask

    task automatic test_async_reset();
        drive_req(2'd0, 2'd0, 2'd2, 1'b0);
        tick();
        drive_req(2'd1, 2'd0, 2'd2, 1'b0);
        tick(); idle();
        checks++; if (req_ready_o !== 1'b0 || empty_o !== 1'b0) begin errors++; $display("FAIL ar_busy got ready %b empty %b want 0 0", req_ready_o, empty_o); end
        #2;
        rst_ni = 0;
        #1;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL ar_ready got %b want 1", req_ready_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL ar_empty got %b want 1", empty_o); end
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL ar_rvalid got %b want 0", result_valid_o); end
        @(negedge clk_i);
        rst_ni = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_ooo();
        test_kill();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
